// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: op codes, FSM states,
// and the mapping from the 2-bit legacy shifter codes onto op.
package shifter_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Legacy 16-bit shifter codes occupy the low bits of op.
  function automatic logic [2:0] legacy_op(input logic [1:0] code);
    return {1'b0, code};
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of up to STEP positions.
// Ports: op (mode), s (positions this step), data, sign (ASR fill)
//        -> res (shifted data), carry (last bit out / wrapped).
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [2:0]       op,
  input  logic [SW-1:0]    s,
  input  logic [WIDTH-1:0] data,
  input  logic             sign,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH:0]   asr_w;
  logic [WIDTH:0]   fill;
  logic [WIDTH-1:0] rol_w;
  logic [WIDTH-1:0] ror_w;
  logic             nz;

  // One guard bit beside the word catches the last bit shifted out.
  assign lsl_w = {1'b0, data} << s;
  assign lsr_w = {data, 1'b0} >> s;
  assign fill  = sign ? ~({(WIDTH+1){1'b1}} >> s) : '0;
  assign asr_w = ({data, 1'b0} >> s) | fill;
  assign rol_w = (data << s) | (data >> (WIDTH - int'(s)));
  assign ror_w = (data >> s) | (data << (WIDTH - int'(s)));
  assign nz    = (s != '0);

  always_comb begin
    res   = data;
    carry = 1'b0;
    unique case (op)
      OP_LSL: begin
        res   = lsl_w[WIDTH-1:0];
        carry = lsl_w[WIDTH];
      end
      OP_LSR: begin
        res   = lsr_w[WIDTH:1];
        carry = lsr_w[0];
      end
      OP_ASR: begin
        res   = asr_w[WIDTH:1];
        carry = asr_w[0];
      end
      OP_ROL: begin
        res   = rol_w;
        carry = nz & rol_w[0];
      end
      OP_ROR: begin
        res   = ror_w;
        carry = nz & ror_w[WIDTH-1];
      end
      default: begin
        res   = data;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROL/ROR shifter, STEP positions per cycle,
// valid/ready on both sides.
// Ports: clk, reset (sync, active-high), in_valid/in_ready, op, amt,
//        din, out_valid/out_ready, dout, cout.
// Option SEQ_SHIFTER_FLAGS_EN adds registered zflag/nflag outputs.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout
`ifdef SEQ_SHIFTER_FLAGS_EN
  ,
  output logic             zflag,
  output logic             nflag
`endif
);

  localparam int SW = $clog2(STEP + 1);
  localparam int LW = $clog2(WIDTH);

  state_e           state;
  state_e           state_nxt;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] eff;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step_res;
  logic [2:0]       op_r;
  logic [SW-1:0]    s;
  logic             sign_r;
  logic             cout_r;
  logic             step_c;
  logic             accept;

  assign accept = in_valid && in_ready;
  assign dout   = work;
  assign cout   = cout_r;

  // Shifts clamp at WIDTH, rotates wrap, PASS/reserved do nothing.
  always_comb begin
    eff = '0;
    unique case (op)
      OP_LSL, OP_LSR, OP_ASR:
        eff = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;
      OP_ROL, OP_ROR:
        eff = AMT_W'(amt[LW-1:0]);
      default:
        eff = '0;
    endcase
  end

  always_comb begin
    s = SW'(STEP);
    if (cnt < AMT_W'(STEP))
      s = SW'(cnt);
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .op   (op_r),
    .s    (s),
    .data (work),
    .sign (sign_r),
    .res  (step_res),
    .carry(step_c)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept)
          state_nxt = (eff == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT:
        if (cnt == AMT_W'(s))
          state_nxt = ST_DONE;
      ST_DONE:
        if (out_ready)
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !reset;
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work   <= '0;
      cnt    <= '0;
      op_r   <= OP_PASS;
      sign_r <= 1'b0;
      cout_r <= 1'b0;
    end else if (accept) begin
      work   <= din;
      cnt    <= eff;
      op_r   <= op;
      sign_r <= din[WIDTH-1];
      if (eff == '0)
        cout_r <= 1'b0;
    end else if (state == ST_SHIFT) begin
      work   <= step_res;
      cout_r <= step_c;
      cnt    <= cnt - AMT_W'(s);
    end
  end

`ifdef SEQ_SHIFTER_FLAGS_EN
  logic [WIDTH-1:0] work_nxt;

  always_comb begin
    work_nxt = work;
    if (accept)
      work_nxt = din;
    else if (state == ST_SHIFT)
      work_nxt = step_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zflag <= 1'b0;
      nflag <= 1'b0;
    end else if (state != ST_DONE &&
                 state_nxt == ST_DONE) begin
      zflag <= (work_nxt == '0);
      nflag <= work_nxt[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances share stimulus;
// table vectors, hand sequences and random ops vs a bit-serial model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [4:0]  amt = 5'd0;
  logic [15:0] din = 16'd0;

  logic        in_ready1, out_valid1, cout1;
  logic        in_ready4, out_valid4, cout4;
  logic [15:0] dout1, dout4;
`ifdef SEQ_SHIFTER_FLAGS_EN
  logic        zflag1, nflag1, zflag4, nflag4;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .amt(amt), .din(din),
    .out_valid(out_valid1), .out_ready(out_ready),
    .dout(dout1), .cout(cout1)
`ifdef SEQ_SHIFTER_FLAGS_EN
    , .zflag(zflag1), .nflag(nflag1)
`endif
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .amt(amt), .din(din),
    .out_valid(out_valid4), .out_ready(out_ready),
    .dout(dout4), .cout(cout4)
`ifdef SEQ_SHIFTER_FLAGS_EN
    , .zflag(zflag4), .nflag(nflag4)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [15:0] din;
    logic [15:0] dout;
    logic        cout;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference: apply the shift one position at a time.
  function automatic void model(input logic [2:0] o,
                                input logic [4:0] a,
                                input logic [15:0] d,
                                output logic [15:0] r,
                                output logic c,
                                output int n);
    logic msb;
    msb = d[15];
    r = d;
    c = 1'b0;
    case (o)
      3'd1, 3'd2, 3'd3: n = (a > 5'd16) ? 16 : int'(a);
      3'd4, 3'd5:       n = int'(a) % 16;
      default:          n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd1: begin c = r[15]; r = {r[14:0], 1'b0};  end
        3'd2: begin c = r[0];  r = {1'b0, r[15:1]};  end
        3'd3: begin c = r[0];  r = {msb, r[15:1]};   end
        3'd4: begin c = r[15]; r = {r[14:0], r[15]}; end
        default: begin c = r[0]; r = {r[0], r[15:1]}; end
      endcase
    end
  endfunction

  function automatic int lat_of(input int n, input int step);
    return 1 + (n + step - 1) / step;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [4:0] a,
                        input logic [15:0] d,
                        output logic [15:0] r1, output logic c1,
                        output int l1,
                        output logic [15:0] r4, output logic c4,
                        output int l4);
    int c;
    chk("pre_ready1", in_ready1, 1);
    chk("pre_ready4", in_ready4, 1);
    op = o;
    amt = a;
    din = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 1;
    l1 = 0;
    l4 = 0;
    while (1) begin
      if (out_valid1 && l1 == 0) l1 = c;
      if (out_valid4 && l4 == 0) l4 = c;
      if ((l1 != 0 && l4 != 0) || c > 60) break;
      tick();
      c++;
    end
    chk("done1", out_valid1, 1);
    chk("done4", out_valid4, 1);
    r1 = dout1;
    c1 = cout1;
    r4 = dout4;
    c4 = cout4;
  endtask

  task automatic check(input string nm,
                       input logic [15:0] r1, input logic c1,
                       input int l1,
                       input logic [15:0] r4, input logic c4,
                       input int l4,
                       input logic [15:0] er, input logic ec,
                       input int el1, input int el4);
    chk({nm, "_dout1"}, r1, er);
    chk({nm, "_cout1"}, c1, ec);
    chk({nm, "_lat1"},  l1, el1);
    chk({nm, "_dout4"}, r4, er);
    chk({nm, "_cout4"}, c4, ec);
    chk({nm, "_lat4"},  l4, el4);
`ifdef SEQ_SHIFTER_FLAGS_EN
    chk({nm, "_z1"}, zflag1, (er == 16'd0));
    chk({nm, "_n1"}, nflag1, er[15]);
    chk({nm, "_z4"}, zflag4, (er == 16'd0));
    chk({nm, "_n4"}, nflag4, er[15]);
`endif
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_valid1", out_valid1, 0);
    chk("rel_valid4", out_valid4, 0);
    chk("rel_ready1", in_ready1, 1);
    chk("rel_ready4", in_ready4, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r1, r4, er;
    logic        c1, c4, ec;
    int          l1, l4, n;

    tbl[0]  = '{3'd1, 5'd1,  16'h8001, 16'h0002, 1'b1, 2,  2};
    tbl[1]  = '{3'd3, 5'd4,  16'h8000, 16'hF800, 1'b0, 5,  2};
    tbl[2]  = '{3'd0, 5'd7,  16'h1234, 16'h1234, 1'b0, 1,  1};
    tbl[3]  = '{3'd5, 5'd20, 16'h0008, 16'h8000, 1'b1, 5,  2};
    tbl[4]  = '{3'd2, 5'd17, 16'hFFFF, 16'h0000, 1'b1, 17, 5};
    tbl[5]  = '{3'd1, 5'd9,  16'h0001, 16'h0200, 1'b0, 10, 4};
    tbl[6]  = '{3'd7, 5'd5,  16'hABCD, 16'hABCD, 1'b0, 1,  1};
    tbl[7]  = '{3'd3, 5'd16, 16'h8001, 16'hFFFF, 1'b1, 17, 5};
    tbl[8]  = '{3'd1, 5'd16, 16'h0001, 16'h0000, 1'b1, 17, 5};
    tbl[9]  = '{3'd4, 5'd16, 16'h1234, 16'h1234, 1'b0, 1,  1};
    tbl[10] = '{3'd4, 5'd3,  16'h9000, 16'h8004, 1'b0, 4,  2};

    tick();
    tick();
    chk("rst_valid1", out_valid1, 0);
    chk("rst_dout1",  dout1, 0);
    chk("rst_cout1",  cout1, 0);
    chk("rst_ready1", in_ready1, 0);
    chk("rst_valid4", out_valid4, 0);
    chk("rst_dout4",  dout4, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready1", in_ready1, 1);
    chk("post_rst_ready4", in_ready4, 1);

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].amt, tbl[i].din,
             r1, c1, l1, r4, c4, l4);
      check($sformatf("tbl%0d", i), r1, c1, l1, r4, c4, l4,
            tbl[i].dout, tbl[i].cout, tbl[i].lat1, tbl[i].lat4);
      release_out();
    end

    // Backpressure: hold the result in DONE for three cycles.
    run_op(3'd1, 5'd2, 16'h4003, r1, c1, l1, r4, c4, l4);
    check("bp", r1, c1, l1, r4, c4, l4, 16'h000C, 1'b1, 3, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_dout1",  dout1, 16'h000C);
      chk("bp_cout1",  cout1, 1);
      chk("bp_valid1", out_valid1, 1);
      chk("bp_ready1", in_ready1, 0);
      chk("bp_dout4",  dout4, 16'h000C);
    end
    release_out();

    // Reset during the third SHIFT cycle of LSL by 10.
    op = 3'd1;
    amt = 5'd10;
    din = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy1", in_ready1, 0);
    reset = 1'b1;
    tick();
    chk("mid_valid1", out_valid1, 0);
    chk("mid_dout1",  dout1, 0);
    chk("mid_cout1",  cout1, 0);
    chk("mid_valid4", out_valid4, 0);
    chk("mid_dout4",  dout4, 0);
    chk("mid_cout4",  cout4, 0);
    reset = 1'b0;
    #1;
    chk("mid_ready1", in_ready1, 1);
    chk("mid_ready4", in_ready4, 1);
    run_op(tbl[0].op, tbl[0].amt, tbl[0].din,
           r1, c1, l1, r4, c4, l4);
    check("after_rst", r1, c1, l1, r4, c4, l4,
          tbl[0].dout, tbl[0].cout, tbl[0].lat1, tbl[0].lat4);
    release_out();

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [4:0]  ra;
      logic [15:0] rd;
      ro = 3'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 31));
      rd = 16'($urandom);
      model(ro, ra, rd, er, ec, n);
      run_op(ro, ra, rd, r1, c1, l1, r4, c4, l4);
      check($sformatf("rnd%0d", i), r1, c1, l1, r4, c4, l4,
            er, ec, lat_of(n, 1), lat_of(n, 4));
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised multi-cycle successor to the datapath 16-bit shifter.
- Shifts WIDTH-bit operands by a variable amount using logical, arithmetic and rotate modes, at STEP bit positions per cycle.
- Valid/ready handshake on both sides; sits between the register-file read port and the ALU result mux.
- Also produces a carry-out (the last bit shifted out).

Parameters:
- WIDTH, 16, operand width; must be a power of two, at least 4.
- STEP, 1, maximum bit positions shifted per cycle; must be at least 1 and no greater than WIDTH.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; equals (state==IDLE) && !reset.
- op  input  3  mode: 000 PASS, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR; 110 and 111 reserved, treated as PASS.
- amt  input  AMT_W  shift amount.
- din  input  WIDTH  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- dout  output  WIDTH  result.
- cout  output  1  last bit shifted out.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, dout=0, cout=0, internal count=0.
- A reset asserted in any state, including mid-SHIFT or DONE, discards the operation and returns to IDLE the next edge.
- Accept: in_valid && in_ready at an edge. That edge latches din, op and the effective count into the working register.
- Effective count at accept:
  - LSL, LSR, ASR: min(amt, WIDTH).
  - ROL, ROR: amt mod WIDTH.
  - PASS and reserved codes: 0.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: on accept, go to DONE if the effective count is 0 (cout cleared); otherwise go to SHIFT.
  - SHIFT: each cycle shift by s = min(STEP, count) and decrement count by s. Go to DONE on the edge where count reaches 0.
  - DONE: out_valid=1; dout and cout are held stable. On out_valid && out_ready, go to IDLE.
- Throughput: in_ready is 0 in SHIFT and DONE, so there is no same-cycle accept on the DONE-exit edge. Throughput is one operation per latency+1 cycles.
- Latency: out_valid rises 1 + ceil(count/STEP) cycles after the accept edge.
- Fill and carry rules:
  - LSL: zero-fill at the LSB.
  - LSR: zero-fill at the MSB.
  - ASR: replicate the original MSB.
  - ROL, ROR: wrap.
  - cout is the bit leaving the word in the final step; for rotates, the bit that wrapped in the final step.
- Saturation: a clamped LSL or LSR by WIDTH gives dout=0, with cout = din[0] for LSL or din[WIDTH-1] for LSR. ASR by WIDTH gives all sign bits, cout = sign.
- dout and cout are undefined-by-contract outside DONE but must not be X after reset. The working register may be visible.

Optional Feature:
- Macro: SEQ_SHIFTER_FLAGS_EN.
- Defined: adds output ports zflag (dout==0) and nflag (dout[WIDTH-1]). Both are registered, update on the edge entering DONE, and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package shifter_pkg holds:
  - the op encodings (OP_PASS … OP_ROR);
  - the state encodings (ST_IDLE, ST_SHIFT, ST_DONE);
  - the rule that the 2-bit legacy codes map to the low bits of op.
- One sub-module, shift_step: a combinational single-step shifter of up to STEP positions. It takes op, s, data and sign, and returns the shifted data and carry. It is instantiated once in seq_shifter.

Test Plan (WIDTH=16, STEP=1 unless noted):
- LSL din=0x8001 amt=1 -> dout=0x0002, cout=1, out_valid 2 cycles after accept.
- ASR din=0x8000 amt=4 -> dout=0xF800, cout=0, latency 5; PASS din=0x1234 -> dout=0x1234, cout=0, latency 1.
- ROR din=0x0008 amt=20 (mod 16 = 4) -> dout=0x8000, cout=1; LSR din=0xFFFF amt=17 (clamped to 16) -> dout=0x0000, cout=1, latency 17.
- STEP=4: LSL din=0x0001 amt=9 -> dout=0x0200, cout=0, latency 1+3=4.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> dout, cout and out_valid stable, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 next cycle.
- Reset asserted on the 3rd SHIFT cycle of LSL amt=10 -> next edge gives IDLE, out_valid=0, dout=0, cout=0; a new request is accepted normally.
